// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;

  typedef enum logic [1:0] {SCAN, CAPTURE, VALID, RELEASE} scan_state_t;

  typedef logic [3:0] key_code_t;

  // Active-low one-hot column drive for a 2-bit column index.
  function automatic logic [N_COLS-1:0] col_drive(input logic [1:0] idx);
    return ~(N_COLS'(1) << idx);
  endfunction

endpackage

// File: rtl/module_row_prio_enc.sv
// Active-low row vector -> {any, index}; the lowest-indexed low row wins.
module module_row_prio_enc
  import keypad_pkg::*;
(
  input  logic [N_ROWS-1:0] rows,
  output logic              any,
  output logic [1:0]        idx
);

  // Walk from the top row down so the lowest low row is the last write.
  always_comb begin
    any = 1'b0;
    idx = 2'd0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) begin
        any = 1'b1;
        idx = 2'(i);
      end
    end
  end

endmodule

// File: rtl/module_key_scanner.sv
// 4x4 keypad scanner: one column driven low at a time, one key code per
// physical press, delivered on a valid/ready handshake.
module module_key_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_stbl,
  output logic [N_COLS-1:0] col,
  output key_code_t         key_code,
  output logic              key_valid,
  input  logic              key_ready
);

  // Reject settle windows the counter cannot reach or that are out of range.
  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255 ||
      (SETTLE_CYCLES - 1) >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("module_key_scanner: SETTLE_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  scan_state_t      state;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [CNT_W-1:0] cnt;
  logic             row_any;
  logic [1:0]       row_enc;

  module_row_prio_enc u_prio (
    .rows (row_stbl),
    .any  (row_any),
    .idx  (row_enc)
  );

  // Column drive is a pure decode of the column register, so it follows
  // reset immediately along with col_idx.
  assign col = col_drive(col_idx);

  // Scan/capture/handshake/release sequencing; counter saturates, never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (row_any) begin
              row_idx <= row_enc;
              state   <= CAPTURE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          key_code  <= {row_idx, col_idx};
          key_valid <= 1'b1;
          cnt       <= '0;
          state     <= VALID;
        end
        VALID: begin
          // Code stays pending even if the key lets go before acceptance.
          if (key_ready) begin
            key_valid <= 1'b0;
            cnt       <= '0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          // Any low row restarts the all-released window (release bounce).
          if (row_stbl != 4'hF) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            col_idx <= col_idx + 2'd1;
            cnt     <= '0;
            state   <= SCAN;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_module_key_scanner.sv
// Bench for module_key_scanner: a physical keypad model feeds row lines from
// the driven column; a behavioural reference predicts col/key_valid/key_code
// every cycle, and directed scenarios pin the expected codes and timing.
module tb_module_key_scanner;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_stbl;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  // pressed[r][c]: key at row r, column c is held down
  logic [3:0][3:0] pressed;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  module_key_scanner #(.SETTLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_stbl  (row_stbl),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready)
  );

  always #5 clk = ~clk;

  // Keypad physics: a row reads low when a held key sits on the driven column.
  always_comb begin
    row_stbl = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col[c]) row_stbl[r] = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // phase: 0 idle sweep, 1 capturing, 2 code offered, 3 waiting for release
  int m_phase, m_col, m_dwell, m_quiet, m_row;
  int m_code;
  bit m_valid;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_col = 0; m_dwell = 0; m_quiet = 0; m_row = 0;
      m_code = 0; m_valid = 0;
    end else begin
      case (m_phase)
        0: begin
          m_dwell++;
          if (m_dwell == SC) begin
            m_dwell = 0;
            if (row_stbl != 4'hF) begin
              m_row = 4;
              for (int r = 3; r >= 0; r--) if (!row_stbl[r]) m_row = r;
              m_phase = 1;
            end else begin
              m_col = (m_col + 1) % 4;
            end
          end
        end
        1: begin
          m_code  = m_row * 4 + m_col;
          m_valid = 1;
          m_phase = 2;
        end
        2: if (key_ready) begin
          m_valid = 0;
          m_quiet = 0;
          m_phase = 3;
        end
        default: begin
          if (row_stbl != 4'hF) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet == SC) begin
              m_col   = (m_col + 1) % 4;
              m_dwell = 0;
              m_phase = 0;
            end
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the reference
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0] ecol;
      ecol = 4'hF;
      ecol[m_col] = 1'b0;
      chk("col", int'(col), int'(ecol));
      chk("key_valid", int'(key_valid), int'(m_valid));
      chk("key_code", int'(key_code), m_code);
    end
  end

  // Accepted transfers and cycles with key_valid high
  int acc[$];
  int vhigh = 0;
  always @(posedge clk) if (rst && key_valid && key_ready) acc.push_back(int'(key_code));
  always @(negedge clk) if (key_valid) vhigh++;

  task automatic wait_valid(input string name);
    int n = 0;
    while (!key_valid && n < 60) begin @(negedge clk); n++; end
    if (!key_valid) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, c0;
    logic [3:0] e, c_frozen;
    rst = 1'b0; pressed = '0; key_ready = 1'b0;

    // 1. reset and sweep
    repeat (3) begin
      @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_col", int'(col), 4'b1110);
      chk("rst_valid", int'(key_valid), 0);
      chk("rst_code", int'(key_code), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = 4'hF;
      e[((i + 1) / 4) % 4] = 1'b0;
      chk("sweep_col", int'(col), int'(e));
    end

    // 2. single press, row 2 col 1, ready high
    key_ready = 1'b1; vhigh = 0; n0 = acc.size();
    pressed[2][1] = 1'b1;
    wait_valid("press9");
    repeat (40) @(negedge clk);
    pressed = '0;
    repeat (20) @(negedge clk);
    chk("press9_count", acc.size() - n0, 1);
    if (acc.size() > n0) chk("press9_code", acc[n0], 9);
    chk("press9_vhigh", vhigh, 1);

    // 3. back-pressure, row 0 col 3, key let go while pending
    key_ready = 1'b0; n0 = acc.size();
    pressed[0][3] = 1'b1;
    wait_valid("bp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) pressed = '0;
      chk("bp_valid", int'(key_valid), 1);
      chk("bp_code", int'(key_code), 3);
    end
    key_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop", int'(key_valid), 0);
    chk("bp_count", acc.size() - n0, 1);
    if (acc.size() > n0) chk("bp_acc", acc[n0], 3);
    repeat (20) @(negedge clk);

    // 4. rows 1 and 3 on column 0
    n0 = acc.size();
    pressed[1][0] = 1'b1; pressed[3][0] = 1'b1;
    wait_valid("multi");
    @(negedge clk);
    pressed = '0;
    repeat (20) @(negedge clk);
    chk("multi_count", acc.size() - n0, 1);
    if (acc.size() > n0) chk("multi_code", acc[n0], 4);

    // 5. release bounce on row 2, column 2
    n0 = acc.size();
    pressed[2][2] = 1'b1;
    wait_valid("bounce");
    @(negedge clk);
    chk("bounce_acc", int'(key_valid), 0);
    c_frozen = col;
    for (int i = 0; i < 12; i++) begin
      pressed[2][2] = ((i / 2) % 2) == 0;
      @(negedge clk);
      chk("bounce_frozen", int'(col), int'(c_frozen));
    end
    pressed = '0;
    c0 = 0;
    while (col == c_frozen && c0 < 10) begin @(negedge clk); c0++; end
    chk("bounce_adv", int'(col), 4'b0111);
    repeat (40) @(negedge clk);
    chk("bounce_count", acc.size() - n0, 1);
    if (acc.size() > n0) chk("bounce_code", acc[n0], 10);

    // 6. asynchronous reset with a code pending
    key_ready = 1'b0;
    pressed[1][2] = 1'b1;
    wait_valid("mrst");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", int'(key_valid), 0);
    chk("mrst_col", int'(col), 4'b1110);
    chk("mrst_code", int'(key_code), 0);
    pressed = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_restart", int'(col), 4'b1110);
    repeat (3) @(negedge clk);
    chk("mrst_next", int'(col), 4'b1101);

    // randomized keypad activity and back-pressure
    n0 = acc.size();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      key_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 11) == 0)
        pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 59) == 0) pressed = '0;
    end
    pressed = '0; key_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("rand_codes_seen", int'(acc.size() > n0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
